alu_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 32-bit ALU (operands a/b, shamt, funct, clocked result) between two requesters.
- Each requester submits a complete operation on a valid/ready handshake and receives the 32-bit result on a valid/ready response channel.
- Only one operation is in flight at a time.
- Sits between the switch/button operand loaders (or any client) and the shared ALU instance.

---
 rtl/alu_rr_sched_pkg.sv | 22 ++
 rtl/alu_rr_sched_if.sv | 48 ++++
 rtl/alu_rr_sched_rr_arb2.sv | 20 ++
 rtl/alu_rr_sched.sv | 110 +++++++++++
 tb/tb_alu_rr_sched.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rr_sched_pkg.sv
// Shared widths, FSM encoding and operand bundle for the ALU round-robin scheduler.
// The ALU itself uses the same width constants.
package alu_rr_sched_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic [SHAMT_W-1:0]       shamt;
    logic [FUNCT_W-1:0]       funct;
  } op_t;

endpackage

// File: rtl/alu_rr_sched_if.sv
// Bus bundle for the scheduler: two requester channels, the shared ALU port and busy.
// slave = scheduler side, master = clients plus ALU side.
interface alu_rr_sched_if;
  import alu_rr_sched_pkg::*;

  logic                      r0_valid;
  logic                      r0_ready;
  logic signed [DATA_W-1:0]  r0_a;
  logic signed [DATA_W-1:0]  r0_b;
  logic [SHAMT_W-1:0]        r0_shamt;
  logic [FUNCT_W-1:0]        r0_funct;
  logic                      r0_rvalid;
  logic                      r0_rready;

  logic                      r1_valid;
  logic                      r1_ready;
  logic signed [DATA_W-1:0]  r1_a;
  logic signed [DATA_W-1:0]  r1_b;
  logic [SHAMT_W-1:0]        r1_shamt;
  logic [FUNCT_W-1:0]        r1_funct;
  logic                      r1_rvalid;
  logic                      r1_rready;

  logic [DATA_W-1:0]         rdata;
  logic signed [DATA_W-1:0]  alu_a;
  logic signed [DATA_W-1:0]  alu_b;
  logic [SHAMT_W-1:0]        alu_shamt;
  logic [FUNCT_W-1:0]        alu_funct;
  logic [DATA_W-1:0]         alu_res;
  logic                      busy;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_shamt, r0_funct, r0_rready,
    input  r1_valid, r1_a, r1_b, r1_shamt, r1_funct, r1_rready,
    input  alu_res,
    output r0_ready, r0_rvalid, r1_ready, r1_rvalid,
    output rdata, alu_a, alu_b, alu_shamt, alu_funct, busy
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_shamt, r0_funct, r0_rready,
    output r1_valid, r1_a, r1_b, r1_shamt, r1_funct, r1_rready,
    output alu_res,
    input  r0_ready, r0_rvalid, r1_ready, r1_rvalid,
    input  rdata, alu_a, alu_b, alu_shamt, alu_funct, busy
  );

endinterface

// File: rtl/alu_rr_sched_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to prio.
// Purely combinational.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_prio,
  output logic       o_grant,
  output logic       o_grant_vld
);

  always_comb begin
    o_grant_vld = |i_valid;
    o_grant     = 1'b0;
    case (i_valid)
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = i_prio;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one ALU between two requesters; one operation in flight, result held until consumed.
// Priority flips to the other requester only when a response completes.
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 3
) (
  input logic           clk,
  input logic           rst,
  alu_rr_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(ALU_LAT);

  if ((2 ** CNT_W) <= ALU_LAT) begin : g_cnt_w_chk
    $error("CNT_W is too narrow to hold ALU_LAT");
  end

  state_t            r_state;
  logic              r_prio;
  logic              r_owner;
  logic [CNT_W-1:0]  r_cnt;
  op_t               r_op;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              r_busy;

  logic              w_grant;
  logic              w_gvld;
  logic              w_idle;
  logic              w_rready;
  op_t               w_op0;
  op_t               w_op1;

  rr_arb2 u_arb (
    .i_valid     ({bus.r1_valid, bus.r0_valid}),
    .i_prio      (r_prio),
    .o_grant     (w_grant),
    .o_grant_vld (w_gvld)
  );

  assign w_idle   = (r_state == IDLE);
  assign w_op0    = {bus.r0_a, bus.r0_b, bus.r0_shamt, bus.r0_funct};
  assign w_op1    = {bus.r1_a, bus.r1_b, bus.r1_shamt, bus.r1_funct};
  assign w_rready = r_owner ? bus.r1_rready : bus.r0_rready;

  // Ready is the only combinational output; everything else comes straight from registers.
  assign bus.r0_ready  = w_idle && bus.r0_valid && w_gvld && !w_grant;
  assign bus.r1_ready  = w_idle && bus.r1_valid && w_gvld &&  w_grant;
  assign bus.r0_rvalid = r_rvalid0;
  assign bus.r1_rvalid = r_rvalid1;
  assign bus.rdata     = r_rdata;
  assign bus.alu_a     = r_op.a;
  assign bus.alu_b     = r_op.b;
  assign bus.alu_shamt = r_op.shamt;
  assign bus.alu_funct = r_op.funct;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_rdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gvld) begin
            r_owner <= w_grant;
            r_op    <= w_grant ? w_op1 : w_op0;
            r_cnt   <= LAT_LD;
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // Counter reaching zero means alu_res now reflects the held operands.
          if (r_cnt == '0) begin
            r_rdata   <= bus.alu_res;
            r_rvalid0 <= !r_owner;
            r_rvalid1 <= r_owner;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (w_rready) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_prio    <= !r_owner;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: directed scenarios plus randomized operands, checked against a
// transaction-level model (per-requester op queues, expected grant owner, fixed response latency).
module tb_alu_rr_sched;

  localparam int LAT = 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [3:0]  fn;
  } req_t;

  logic clk;
  logic rst;

  alu_rr_sched_if bus ();

  alu_rr_sched #(
    .ALU_LAT (LAT),
    .CNT_W   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk;
  int   n_pass;
  int   n_fail;
  int   ref_prio;
  int   grant_log[$];
  req_t q0[$];
  req_t q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic [3:0] fn);
    case (fn)
      4'd0:    return a + b;
      4'd1:    return a << sh;
      default: return 32'h0;
    endcase
  endfunction

  // Registered ALU with one cycle of latency.
  always_ff @(posedge clk)
    bus.alu_res <= ref_alu(bus.alu_a, bus.alu_b, bus.alu_shamt, bus.alu_funct);

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int log_code();
    int c = 0;
    foreach (grant_log[i]) c = c * 10 + grant_log[i] + 1;
    return c;
  endfunction

  function automatic req_t rnd_req(input int fn);
    req_t r;
    r.a  = $urandom;
    r.b  = $urandom;
    r.sh = 5'($urandom_range(0, 31));
    r.fn = 4'(fn);
    return r;
  endfunction

  // Plays both requester queues through the DUT until every op has been answered.
  // Entered and left at posedge+1. dN delays the first valid of requester N by that many cycles.
  task automatic run_engine(input int budget, input int stall, input int d0, input int d1);
    int          n, owner, t_acc, rv_seen, g, age;
    bit          pop0, pop1, done;
    req_t        cur;
    logic [31:0] exp_res;
    n = 0; owner = -1; t_acc = 0; rv_seen = 0; cur = '0; exp_res = '0;
    while ((q0.size() > 0 || q1.size() > 0 || owner >= 0) && n < budget) begin
      pop0 = 0; pop1 = 0; done = 0;
      bus.r0_valid = (q0.size() > 0) && (n >= d0);
      bus.r1_valid = (q1.size() > 0) && (n >= d1);
      if (q0.size() > 0) begin
        bus.r0_a = q0[0].a; bus.r0_b = q0[0].b; bus.r0_shamt = q0[0].sh; bus.r0_funct = q0[0].fn;
      end
      if (q1.size() > 0) begin
        bus.r1_a = q1[0].a; bus.r1_b = q1[0].b; bus.r1_shamt = q1[0].sh; bus.r1_funct = q1[0].fn;
      end
      bus.r0_rready = (owner != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.r1_rready = (owner != 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (owner < 0) begin
        g = -1;
        if (bus.r0_valid && bus.r1_valid) g = ref_prio;
        else if (bus.r0_valid)            g = 0;
        else if (bus.r1_valid)            g = 1;
        chk("idle_r0_ready", bus.r0_ready, g == 0);
        chk("idle_r1_ready", bus.r1_ready, g == 1);
        chk("idle_busy", bus.busy, 1'b0);
        if (g >= 0) begin
          owner   = g;
          cur     = (g == 1) ? q1[0] : q0[0];
          exp_res = ref_alu(cur.a, cur.b, cur.sh, cur.fn);
          t_acc   = n;
          rv_seen = 0;
          pop0    = (g == 0);
          pop1    = (g == 1);
        end
      end else begin
        age = n - t_acc;
        chk("busy_flag", bus.busy, 1'b1);
        chk("busy_no_ready", {bus.r0_ready, bus.r1_ready}, 2'b00);
        if (age == 1)
          chk("alu_operands", {bus.alu_a, bus.alu_b, bus.alu_shamt, bus.alu_funct},
              {cur.a, cur.b, cur.sh, cur.fn});
        chk("rvalid_owner", (owner == 1) ? bus.r1_rvalid : bus.r0_rvalid, age >= LAT + 2);
        chk("rvalid_other", (owner == 1) ? bus.r0_rvalid : bus.r1_rvalid, 1'b0);
        if (age >= LAT + 2) begin
          chk("rdata", bus.rdata, exp_res);
          rv_seen++;
          if (rv_seen > stall) begin
            if (owner == 1) bus.r1_rready = 1'b1;
            else            bus.r0_rready = 1'b1;
            done = 1;
          end
        end
      end
      @(posedge clk); #1;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (done) begin
        grant_log.push_back(owner);
        ref_prio = 1 - owner;
        owner    = -1;
      end
      n++;
    end
    chk("engine_drained", (q0.size() == 0) && (q1.size() == 0) && (owner < 0), 1'b1);
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    bus.r0_rready = 1'b0; bus.r1_rready = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; ref_prio = 0;
    bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_shamt = '0; bus.r0_funct = '0;
    bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_shamt = '0; bus.r1_funct = '0;
    bus.r0_rready = 1'b0; bus.r1_rready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ctrl", {bus.busy, bus.r0_ready, bus.r1_ready, bus.r0_rvalid, bus.r1_rvalid}, 5'b0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_alu", {bus.alu_a, bus.alu_b, bus.alu_shamt, bus.alu_funct}, 73'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention straight out of reset: r0 first, then r1.
    grant_log.delete();
    q0.push_back('{a: 32'd1, b: 32'd2, sh: 5'd0, fn: 4'd0});
    q1.push_back('{a: 32'd10, b: 32'd20, sh: 5'd0, fn: 4'd0});
    run_engine(200, 0, 0, 0);
    chk("contention_order", log_code(), 12);

    // Both requesters hold valid across four random additions.
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rnd_req(0));
      q1.push_back(rnd_req(0));
    end
    run_engine(400, 0, 0, 0);
    chk("fair_order", log_code(), 1212);

    // Single request 5 + 7.
    q0.push_back('{a: 32'd5, b: 32'd7, sh: 5'd0, fn: 4'd0});
    run_engine(200, 0, 0, 0);

    // Response stall on r1 overflow-wrapping add while r0 waits.
    grant_log.delete();
    q1.push_back('{a: 32'h7FFF_FFFF, b: 32'd1, sh: 5'd0, fn: 4'd0});
    q0.push_back(rnd_req(0));
    run_engine(300, 5, 1, 0);
    chk("stall_order", log_code(), 21);

    // Shift with maximum shamt.
    q0.push_back('{a: 32'd1, b: $urandom, sh: 5'd31, fn: 4'd1});
    run_engine(200, 0, 0, 0);

    // Mixed random ops with a random response stall.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rnd_req($urandom_range(0, 2)));
      q1.push_back(rnd_req($urandom_range(0, 2)));
    end
    run_engine(1000, $urandom_range(0, 3), 0, $urandom_range(0, 3));

    // Reset in the first WAIT cycle aborts the op.
    bus.r0_valid = 1'b1; bus.r0_a = 32'd3; bus.r0_b = 32'd4; bus.r0_shamt = '0; bus.r0_funct = '0;
    @(negedge clk);
    chk("abort_ready", bus.r0_ready, 1'b1);
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_wait", bus.busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state", {bus.busy, bus.r0_rvalid, bus.r1_rvalid}, 3'b0);
    chk("abort_rdata", bus.rdata, 32'h0);
    chk("abort_alu_a", bus.alu_a, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_no_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b00);
    end
    @(posedge clk); #1;
    ref_prio = 0;
    q0.push_back('{a: 32'd3, b: 32'd4, sh: 5'd0, fn: 4'd0});
    run_engine(200, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
